// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control/interlock unit: stage indices and
// the shadow record tracked for every in-flight stage from EX onward.
package pipeline_ctrl_pkg;

    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    // Shadow dest field is sized for the widest supported register address.
    localparam int MAX_REG_ADDR_WIDTH = 8;

    typedef struct packed {
        logic                          valid;
        logic [MAX_REG_ADDR_WIDTH-1:0] dest;
        logic                          regwrite;
        logic                          is_load;
    } stage_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Combinational read-after-write hazard detection between the ID instruction's
// sources and the in-flight writers held in the shadow stages.
module pipeline_ctrl_hazard
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FORWARD_EN     = 0
) (
    input  logic                                  id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]             id_rs,
    input  logic [REG_ADDR_WIDTH-1:0]             id_rt,
    input  logic                                  id_use_rs,
    input  logic                                  id_use_rt,
    input  stage_state_t [NUM_STAGES-1:STAGE_EX]  shadow,
    output logic                                  hazard
);

    logic [MAX_REG_ADDR_WIDTH-1:0] rs_ext_s;
    logic [MAX_REG_ADDR_WIDTH-1:0] rt_ext_s;

    assign rs_ext_s = MAX_REG_ADDR_WIDTH'(id_rs);
    assign rt_ext_s = MAX_REG_ADDR_WIDTH'(id_rt);

    // With forwarding only a load still in EX cannot supply its result in time;
    // without it every writer before WB interlocks (WB writes the file first).
    function automatic logic in_window(input int s, input logic is_load);
        if (FORWARD_EN != 0) begin
            return (s == STAGE_EX) && is_load;
        end else begin
            return s <= NUM_STAGES - 2;
        end
    endfunction

    function automatic logic src_match(input logic used,
                                       input logic [MAX_REG_ADDR_WIDTH-1:0] src,
                                       input stage_state_t st);
        return used && (src != {MAX_REG_ADDR_WIDTH{1'b0}}) && (src == st.dest)
               && st.valid && st.regwrite;
    endfunction

    // OR together every source/stage match that falls inside the hazard window.
    always_comb begin
        hazard = 1'b0;
        for (int s = STAGE_EX; s < NUM_STAGES; s++) begin
            hazard = hazard | (in_window(s, shadow[s].is_load)
                     & (src_match(id_use_rs, rs_ext_s, shadow[s])
                      | src_match(id_use_rt, rt_ext_s, shadow[s])));
        end
        hazard = hazard & id_valid;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control and interlock unit: tracks per-stage validity, resolves
// stalls (RAW hazards, UART back-pressure) and branch flushes, counts both.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int NUM_STAGES     = 5,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BRANCH_STAGE   = 4,
    parameter int FORWARD_EN     = 0,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      fetch_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_use_rs,
    input  logic                      id_use_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_dest,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      id_uart_in,
    input  logic                      id_uart_out,
    input  logic                      uart_in_ready,
    input  logic                      uart_out_ready,
    input  logic                      branch_taken,
    output logic                      pc_enable,
    output logic                      ifid_enable,
    output logic                      idex_bubble,
    output logic                      flush,
    output logic [NUM_STAGES-1:0]     stage_valid,
    output logic [COUNT_WIDTH-1:0]    stall_count,
    output logic [COUNT_WIDTH-1:0]    flush_count
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                                 if_valid_r;
    logic                                 id_valid_r;
    stage_state_t [NUM_STAGES-1:STAGE_EX] shadow_r;
    logic [COUNT_WIDTH-1:0]               stall_count_r;
    logic [COUNT_WIDTH-1:0]               flush_count_r;

    logic [NUM_STAGES-1:0]                stage_valid_s;
    stage_state_t [NUM_STAGES-1:STAGE_EX] shadow_next_s;
    logic                                 hazard_s;
    logic                                 uart_stall_s;
    logic                                 flush_s;
    logic                                 stall_s;
    logic                                 if_valid_next_s;
    logic                                 id_valid_next_s;

    pipeline_ctrl_hazard #(
        .NUM_STAGES     (NUM_STAGES),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .FORWARD_EN     (FORWARD_EN)
    ) u_hazard (
        .id_valid  (id_valid_r),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .shadow    (shadow_r),
        .hazard    (hazard_s)
    );

    // Gather the registered valid bits into one vector.
    always_comb begin
        stage_valid_s           = {NUM_STAGES{1'b0}};
        stage_valid_s[STAGE_IF] = if_valid_r;
        stage_valid_s[STAGE_ID] = id_valid_r;
        for (int s = STAGE_EX; s < NUM_STAGES; s++) begin
            stage_valid_s[s] = shadow_r[s].valid;
        end
    end

    // Stall/flush decision; a flush overrides any stall in the same cycle.
    always_comb begin
        uart_stall_s = id_valid_r & ((id_uart_in & ~uart_in_ready)
                                   | (id_uart_out & ~uart_out_ready));
        flush_s      = branch_taken & stage_valid_s[BRANCH_STAGE];
        stall_s      = (hazard_s | uart_stall_s) & ~flush_s;
        if (reset) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            flush       = 1'b1;
        end else begin
            pc_enable   = ~stall_s;
            ifid_enable = ~stall_s;
            idex_bubble = stall_s | flush_s;
            flush       = flush_s;
        end
    end

    // Next-state of the stage shadows: shift forward, bubble into EX, squash on flush.
    always_comb begin
        shadow_next_s = shadow_r;
        if (stall_s || flush_s) begin
            shadow_next_s[STAGE_EX] = '{valid: 1'b0, dest: {MAX_REG_ADDR_WIDTH{1'b0}},
                                        regwrite: 1'b0, is_load: 1'b0};
        end else begin
            shadow_next_s[STAGE_EX] = '{valid: id_valid_r,
                                        dest: MAX_REG_ADDR_WIDTH'(id_dest),
                                        regwrite: id_regwrite, is_load: id_is_load};
        end
        for (int s = STAGE_EX + 1; s < NUM_STAGES; s++) begin
            shadow_next_s[s] = shadow_r[s-1];
            if (flush_s && (s < BRANCH_STAGE)) begin
                shadow_next_s[s].valid = 1'b0;
            end else begin
                shadow_next_s[s].valid = shadow_r[s-1].valid;
            end
        end
        if (flush_s) begin
            if_valid_next_s = 1'b0;
            id_valid_next_s = 1'b0;
        end else if (stall_s) begin
            if_valid_next_s = if_valid_r;
            id_valid_next_s = id_valid_r;
        end else begin
            if_valid_next_s = fetch_valid;
            id_valid_next_s = fetch_valid;
        end
    end

    // Stage state and saturating performance counters.
    always_ff @(posedge CLK) begin
        if (reset) begin
            if_valid_r    <= 1'b0;
            id_valid_r    <= 1'b0;
            shadow_r      <= '0;
            stall_count_r <= {COUNT_WIDTH{1'b0}};
            flush_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            if_valid_r <= if_valid_next_s;
            id_valid_r <= id_valid_next_s;
            shadow_r   <= shadow_next_s;
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + COUNT_WIDTH'(1'b1);
            end
            if (flush_s && (flush_count_r != CNT_MAX)) begin
                flush_count_r <= flush_count_r + COUNT_WIDTH'(1'b1);
            end
        end
    end

    assign stage_valid = stage_valid_s;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: a full-interlock and a forwarding (3-bit counter) instance
// share one directed stimulus and are checked every cycle against a stage model.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_valid = 1'b1;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_dest = 5'd0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwrite = 1'b0, id_is_load = 1'b0;
    logic       id_uart_in = 1'b0, id_uart_out = 1'b0;
    logic       uart_in_ready = 1'b1, uart_out_ready = 1'b1, branch_taken = 1'b0;

    logic        pc0, ifid0, bub0, fl0, pc1, ifid1, bub1, fl1;
    logic [4:0]  sv0, sv1;
    logic [31:0] sc0, fc0;
    logic [2:0]  sc1, fc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.FORWARD_EN(0)) dut0 (
        .CLK(CLK), .reset(reset), .fetch_valid(fetch_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_uart_in(id_uart_in), .id_uart_out(id_uart_out),
        .uart_in_ready(uart_in_ready), .uart_out_ready(uart_out_ready),
        .branch_taken(branch_taken), .pc_enable(pc0), .ifid_enable(ifid0),
        .idex_bubble(bub0), .flush(fl0), .stage_valid(sv0),
        .stall_count(sc0), .flush_count(fc0));

    pipeline_ctrl #(.FORWARD_EN(1), .COUNT_WIDTH(3)) dut1 (
        .CLK(CLK), .reset(reset), .fetch_valid(fetch_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .id_uart_in(id_uart_in), .id_uart_out(id_uart_out),
        .uart_in_ready(uart_in_ready), .uart_out_ready(uart_out_ready),
        .branch_taken(branch_taken), .pc_enable(pc1), .ifid_enable(ifid1),
        .idex_bubble(bub1), .flush(fl1), .stage_valid(sv1),
        .stall_count(sc1), .flush_count(fc1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state per instance (0: interlock, 1: forwarding)
    bit          mv  [2][5];
    int          md  [2][5];
    bit          mrw [2][5];
    bit          mld [2][5];
    logic [31:0] msc [2];
    logic [31:0] mfc [2];
    bit          model_ok = 1'b0;

    always @(negedge CLK) begin : model_cmp
        bit idv, fl, hz, us, st, watched;
        bit nv[5]; int nd[5]; bit nrw[5]; bit nld[5];
        logic [31:0] cmax;
        for (int i = 0; i < 2; i++) begin
            cmax = (i == 0) ? 32'hFFFF_FFFF : 32'h7;
            idv = mv[i][1];
            fl  = branch_taken && mv[i][4];
            hz  = 1'b0;
            for (int s = 2; s < 5; s++) begin
                if (i == 1) watched = (s == 2) && mld[i][s];
                else        watched = (s <= 3);
                if (watched && mv[i][s] && mrw[i][s]) begin
                    if (id_use_rs && id_rs != 5'd0 && int'(id_rs) == md[i][s]) hz = 1'b1;
                    if (id_use_rt && id_rt != 5'd0 && int'(id_rt) == md[i][s]) hz = 1'b1;
                end
            end
            hz = hz && idv;
            us = idv && ((id_uart_in && !uart_in_ready) || (id_uart_out && !uart_out_ready));
            st = (hz || us) && !fl;
            if (reset) begin
                check($sformatf("pc_enable_rst%0d", i), (i == 0) ? pc0 : pc1, 0);
                check($sformatf("ifid_enable_rst%0d", i), (i == 0) ? ifid0 : ifid1, 0);
                check($sformatf("idex_bubble_rst%0d", i), (i == 0) ? bub0 : bub1, 1);
                check($sformatf("flush_rst%0d", i), (i == 0) ? fl0 : fl1, 1);
            end else begin
                check($sformatf("pc_enable%0d", i), (i == 0) ? pc0 : pc1, !st);
                check($sformatf("ifid_enable%0d", i), (i == 0) ? ifid0 : ifid1, !st);
                check($sformatf("idex_bubble%0d", i), (i == 0) ? bub0 : bub1, st || fl);
                check($sformatf("flush%0d", i), (i == 0) ? fl0 : fl1, fl);
            end
            if (model_ok) begin
                check($sformatf("stage_valid%0d", i), (i == 0) ? sv0 : sv1,
                      {mv[i][4], mv[i][3], mv[i][2], mv[i][1], mv[i][0]});
                check($sformatf("stall_count%0d", i), (i == 0) ? sc0 : {29'd0, sc1}, msc[i]);
                check($sformatf("flush_count%0d", i), (i == 0) ? fc0 : {29'd0, fc1}, mfc[i]);
            end
            for (int s = 0; s < 5; s++) begin
                nv[s] = 1'b0; nd[s] = 0; nrw[s] = 1'b0; nld[s] = 1'b0;
            end
            if (reset) begin
                msc[i] = 32'd0;
                mfc[i] = 32'd0;
            end else begin
                for (int s = 3; s < 5; s++) begin
                    nv[s] = mv[i][s-1]; nd[s] = md[i][s-1];
                    nrw[s] = mrw[i][s-1]; nld[s] = mld[i][s-1];
                end
                if (!(st || fl)) begin
                    nv[2] = idv; nd[2] = int'(id_dest);
                    nrw[2] = id_regwrite; nld[2] = id_is_load;
                end
                nv[1] = st ? mv[i][1] : fetch_valid;
                nv[0] = st ? mv[i][0] : fetch_valid;
                if (fl) for (int s = 0; s < 4; s++) nv[s] = 1'b0;
                if (st && msc[i] != cmax) msc[i] = msc[i] + 32'd1;
                if (fl && mfc[i] != cmax) mfc[i] = mfc[i] + 32'd1;
            end
            for (int s = 0; s < 5; s++) begin
                mv[i][s] = nv[s]; md[i][s] = nd[s]; mrw[i][s] = nrw[s]; mld[i][s] = nld[s];
            end
        end
        if (reset) model_ok = 1'b1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_id();
        id_rs = 5'd0; id_rt = 5'd0; id_dest = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0;
        id_uart_in = 1'b0; id_uart_out = 1'b0;
        uart_in_ready = 1'b1; uart_out_ready = 1'b1; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; fetch_valid = 1'b1; idle_id();
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic writer(input logic [4:0] d, input logic ld);
        idle_id(); id_dest = d; id_regwrite = 1'b1; id_is_load = ld;
    endtask

    initial begin
        // Load-use: forwarding stalls once, interlock twice
        do_reset(); tick();
        writer(5'd3, 1'b1); tick();
        idle_id(); id_rs = 5'd3; id_use_rs = 1'b1; tick(); tick();
        check("lu_stage_valid_fwd0", sv0, 32'h13);
        check("lu_stage_valid_fwd1", sv1, 32'h17);
        tick(); idle_id(); tick();
        check("lu_stall_count_fwd0", sc0, 2);
        check("lu_stall_count_fwd1", sc1, 1);

        // ALU writer of $5: interlock stalls 2 cycles, forwarding none
        do_reset(); tick();
        writer(5'd5, 1'b0); tick();
        idle_id(); id_rt = 5'd5; id_use_rt = 1'b1; tick(); tick(); tick();
        idle_id(); tick();
        check("alu_stall_count_fwd0", sc0, 2);
        check("alu_stall_count_fwd1", sc1, 0);

        // Branch taken in stage 4
        do_reset(); tick(); tick(); tick(); tick();
        check("br_pre_stage_valid", sv0, 32'h1F);
        branch_taken = 1'b1; #1;
        check("br_flush_fwd0", fl0, 1);
        check("br_pc_enable_fwd1", pc1, 1);
        tick(); branch_taken = 1'b0;
        check("br_stage_valid_fwd0", sv0, 32'h10);
        check("br_stage_valid_fwd1", sv1, 32'h10);
        check("br_flush_count_fwd1", fc1, 1);

        // Branch and hazard in the same cycle
        do_reset(); writer(5'd7, 1'b1); tick(); tick(); tick(); tick();
        idle_id(); id_rs = 5'd7; id_use_rs = 1'b1; branch_taken = 1'b1; #1;
        check("brhz_pc_enable_fwd0", pc0, 1);
        check("brhz_flush_fwd1", fl1, 1);
        tick(); idle_id();
        check("brhz_stall_count_fwd0", sc0, 0);
        check("brhz_stall_count_fwd1", sc1, 0);
        check("brhz_flush_count_fwd0", fc0, 1);

        // UART sender back-pressure for 7 cycles, then 2 more to saturate dut1
        do_reset(); tick();
        id_uart_out = 1'b1; uart_out_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1; check($sformatf("uart_pc_enable_low_%0d", k), {31'd0, pc0 | pc1}, 0);
            tick();
        end
        uart_out_ready = 1'b1; #1;
        check("uart_release_fwd0", pc0, 1);
        check("uart_release_fwd1", pc1, 1);
        tick();
        check("uart_stall_count_fwd0", sc0, 7);
        uart_out_ready = 1'b0; tick(); tick();
        idle_id(); tick();
        check("uart_sat_count_fwd0", sc0, 9);
        check("uart_sat_count_fwd1", sc1, 7);

        // Destination $0 never interlocks
        do_reset(); tick();
        writer(5'd0, 1'b1); tick();
        idle_id(); id_rs = 5'd0; id_use_rs = 1'b1; id_rt = 5'd0; id_use_rt = 1'b1; #1;
        check("r0_pc_enable_fwd0", pc0, 1);
        check("r0_pc_enable_fwd1", pc1, 1);
        tick();

        // Reset asserted in the middle of a stall
        writer(5'd9, 1'b1); tick();
        idle_id(); id_rs = 5'd9; id_use_rs = 1'b1; #1;
        check("mid_stalled_fwd0", pc0, 0);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_stage_valid_fwd0", sv0, 0);
        check("rst_stage_valid_fwd1", sv1, 0);
        check("rst_stall_count_fwd0", sc0, 0);
        check("rst_flush_count_fwd1", fc1, 0);
        #1;
        check("rst_no_stall_fwd0", pc0, 1);
        tick(); tick(); idle_id(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
